// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Largest value representable in 'digits' decimal digits (10^digits - 1).
    function automatic logic [63:0] max_dec(input int unsigned digits);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        if (v > 1) begin
            for (int unsigned w = v - 1; w > 0; w = w >> 1) begin
                r++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more.
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit_c
);

    assign o_digit_c = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter, one bit per clock; result register holds
// between conversions and shows blank digits when the value does not fit.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd_out,
    output logic                  o_ovf
);

    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned WORK_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W   = clog2(BIN_W + 1);
    localparam logic [63:0] MAX_DEC = max_dec(DIGITS);

    state_t              r_state, w_state_next;
    logic [WORK_W-1:0]   r_work, w_work_next, w_shifted;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic                r_ovf_pend, w_ovf_pend_next;
    logic [BCD_W-1:0]    r_bcd_out, w_bcd_out_next, w_adj;
    logic                r_ovf, w_ovf_next;
    logic                r_busy, r_done;
    logic                w_last;
    logic                w_ovf_cap;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .i_digit   (r_work[BIN_W + 4*g +: 4]),
                .o_digit_c (w_adj[4*g +: 4])
            );
        end
    endgenerate

    // Correct-then-shift happens in a single cycle; top bit falls off only on overflow.
    assign w_shifted = {w_adj, r_work[BIN_W-1:0]} << 1;
    assign w_last    = (r_cnt == CNT_W'(BIN_W - 1));
    assign w_ovf_cap = (64'(i_bin) > MAX_DEC);

    always_comb begin
        w_state_next    = r_state;
        w_work_next     = r_work;
        w_cnt_next      = r_cnt;
        w_ovf_pend_next = r_ovf_pend;
        w_bcd_out_next  = r_bcd_out;
        w_ovf_next      = r_ovf;
        case (r_state)
            IDLE, FINISH: begin
                w_state_next = IDLE;
                if (i_start) begin
                    w_state_next    = CONV;
                    w_work_next     = {BCD_W'(0), i_bin};
                    w_cnt_next      = '0;
                    w_ovf_pend_next = w_ovf_cap;
                end
            end
            CONV: begin
                w_work_next = w_shifted;
                w_cnt_next  = r_cnt + CNT_W'(1);
                if (w_last) begin
                    w_state_next   = FINISH;
                    w_bcd_out_next = r_ovf_pend ? {DIGITS{DIGIT_BLANK}}
                                                : w_shifted[WORK_W-1 -: BCD_W];
                    w_ovf_next     = r_ovf_pend;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_work     <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_bcd_out  <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_work     <= w_work_next;
            r_cnt      <= w_cnt_next;
            r_ovf_pend <= w_ovf_pend_next;
            r_bcd_out  <= w_bcd_out_next;
            r_ovf      <= w_ovf_next;
            r_busy     <= (w_state_next == CONV);
            r_done     <= (w_state_next == FINISH);
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_bcd_out = r_bcd_out;
    assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: default 14-bit/4-digit instance plus
// an 8-bit/3-digit instance swept over every input value.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] bin;
    logic        busy, done, ovf;
    logic [15:0] bcd;

    logic        s8_start;
    logic [7:0]  s8_bin;
    logic        s8_busy, s8_done, s8_ovf;
    logic [11:0] s8_bcd;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_bin(bin),
        .o_busy(busy), .o_done(done), .o_bcd_out(bcd), .o_ovf(ovf)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s8_start), .i_bin(s8_bin),
        .o_busy(s8_busy), .o_done(s8_done), .o_bcd_out(s8_bcd), .o_ovf(s8_ovf)
    );

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Decimal digits by repeated division; blank digits when the value does not fit.
    function automatic logic [63:0] ref_bcd(input int unsigned v, input int unsigned d);
        logic [63:0] r;
        longint unsigned lim;
        int unsigned x;
        r = '0;
        lim = 1;
        x = v;
        for (int i = 0; i < int'(d); i++) lim = lim * 10;
        for (int i = 0; i < int'(d); i++) begin
            if (longint'(v) > lim - 1) r[4*i +: 4] = 4'hF;
            else begin
                r[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int unsigned v, input int unsigned d);
        longint unsigned lim;
        lim = 1;
        for (int i = 0; i < int'(d); i++) lim = lim * 10;
        return longint'(v) > lim - 1;
    endfunction

    // Accept one conversion and return at the sample point where DONE is first seen.
    // lat = edges after the accepting edge; nbusy = sampled cycles with BUSY high.
    task automatic do_conv(input logic [13:0] b, output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1;
        bin   = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_conv8(input logic [7:0] b, output int lat);
        @(negedge clk);
        s8_start = 1'b1;
        s8_bin   = b;
        @(posedge clk);
        @(negedge clk);
        s8_start = 1'b0;
        lat = 0;
        while (!s8_done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t tbl [6];
    int   lat, nbusy, cnt;
    logic [13:0] rv;

    initial begin
        tbl[0] = '{bin: 14'd0,     bcd: 16'h0000, ovf: 1'b0};
        tbl[1] = '{bin: 14'd1234,  bcd: 16'h1234, ovf: 1'b0};
        tbl[2] = '{bin: 14'd9999,  bcd: 16'h9999, ovf: 1'b0};
        tbl[3] = '{bin: 14'd10000, bcd: 16'hFFFF, ovf: 1'b1};
        tbl[4] = '{bin: 14'd16383, bcd: 16'hFFFF, ovf: 1'b1};
        tbl[5] = '{bin: 14'd5,     bcd: 16'h0005, ovf: 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        s8_start = 1'b0;
        s8_bin   = '0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_bcd",  64'(bcd),  64'd0);
        check("reset_ovf",  64'(ovf),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            do_conv(tbl[i].bin, lat, nbusy);
            check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd14);
            check($sformatf("tbl%0d_busy_cycles", i), 64'(nbusy), 64'd14);
            check($sformatf("tbl%0d_bcd", i), 64'(bcd), 64'(tbl[i].bcd));
            check($sformatf("tbl%0d_ovf", i), 64'(ovf), 64'(tbl[i].ovf));
            @(negedge clk);
            check($sformatf("tbl%0d_done_pulse", i), 64'(done), 64'd0);
            check($sformatf("tbl%0d_bcd_hold", i), 64'(bcd), 64'(tbl[i].bcd));
        end

        // Randomized values against the reference model
        for (int i = 0; i < 30; i++) begin
            rv = 14'($urandom_range(0, 16383));
            do_conv(rv, lat, nbusy);
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'd14);
            check($sformatf("rand%0d_bcd(%0d)", i, rv), 64'(bcd), ref_bcd(32'(rv), 4));
            check($sformatf("rand%0d_ovf(%0d)", i, rv), 64'(ovf), 64'(ref_ovf(32'(rv), 4)));
            @(negedge clk);
        end

        // START during BUSY ignored; START in FINISH accepted back-to-back
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd42;
        @(posedge clk);
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            if (k >= 3 && k <= 10) begin
                start = 1'b1;
                bin   = 14'd7;
            end else begin
                start = 1'b0;
            end
            if (k == 13) check("ign_busy_k13", 64'(busy), 64'd1);
            if (k < 14) check($sformatf("ign_no_done_k%0d", k), 64'(done), 64'd0);
        end
        check("ign_done", 64'(done), 64'd1);
        check("ign_bcd", 64'(bcd), 64'h0042);
        start = 1'b1;
        bin   = 14'd7;
        @(posedge clk);
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 0 || k == 7 || k == 13) begin
                check($sformatf("b2b_hold_k%0d", k), 64'(bcd), 64'h0042);
                check($sformatf("b2b_busy_k%0d", k), 64'(busy), 64'd1);
            end
        end
        check("b2b_done", 64'(done), 64'd1);
        check("b2b_bcd", 64'(bcd), 64'h0007);

        // Asynchronous reset in the middle of a conversion
        @(negedge clk);
        do_conv(14'd5678, lat, nbusy);
        check("pre_rst_bcd", 64'(bcd), 64'h5678);
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd321;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_bcd",  64'(bcd),  64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_ovf",  64'(ovf),  64'd0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("rst_no_done", 64'(cnt), 64'd0);
        check("rst_bcd_after", 64'(bcd), 64'd0);
        do_conv(14'd321, lat, nbusy);
        check("post_rst_latency", 64'(lat), 64'd14);
        check("post_rst_bcd", 64'(bcd), 64'h0321);
        @(negedge clk);

        // Second configuration: every 8-bit value
        for (int v = 0; v < 256; v++) begin
            do_conv8(8'(v), lat);
            check($sformatf("w8_latency(%0d)", v), 64'(lat), 64'd8);
            check($sformatf("w8_bcd(%0d)", v), 64'(s8_bcd), ref_bcd(32'(v), 3));
            check($sformatf("w8_ovf(%0d)", v), 64'(s8_ovf), 64'd0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
